// File: rtl/hc165_button_reader.sv
// Scans an external 74HC165 periodically, debounces the byte, and reports changes with strobes.
// Optional HC165_READER_RAW_EN adds o_raw/o_raw_stb to expose each scan's undebounced byte.
module hc165_button_reader #(
  parameter int unsigned SCAN_DIV_RATE  = 25000,
  parameter int unsigned SCAN_DIV_WIDTH = 15,
  parameter int unsigned HALF_PERIOD    = 4,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_shifter_q7,
  output logic       o_shifter_pl_n,
  output logic       o_shifter_cp,
  output logic [7:0] o_buttons,
  output logic       o_buttons_changed_stb,
  output logic       o_scan_done_stb
`ifdef HC165_READER_RAW_EN
  ,
  output logic [7:0] o_raw,
  output logic       o_raw_stb
`endif
);

  localparam int unsigned PHASE_W = $clog2(HALF_PERIOD);
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PHASE_W-1:0]        PHASE_LAST = PHASE_W'(HALF_PERIOD - 1);
  localparam logic [SCAN_DIV_WIDTH-1:0] DIV_LAST   = SCAN_DIV_WIDTH'(SCAN_DIV_RATE - 1);
  localparam logic [CNT_W-1:0]          CNT_THRESH = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSample, StShift, StDone} state_t;

  state_t                    r_state, w_state_next;
  logic [PHASE_W-1:0]        r_phase, w_phase_next;
  logic [SCAN_DIV_WIDTH-1:0] r_div;
  logic [2:0]                r_bit_cnt;
  logic [7:0]                r_shift;
  logic [7:0]                r_prev_raw;
  logic [7:0]                r_buttons;
  logic [CNT_W-1:0]          r_stable_cnt;
  logic                      r_q7_meta, r_q7_sync;
  logic                      r_pl_n, r_cp, r_done_stb, r_changed_stb;

  logic                      w_tick, w_phase_end, w_sample, w_accept;
  logic [7:0]                w_raw;
  logic [CNT_W-1:0]          w_cnt_next;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_phase_end = (r_phase == PHASE_LAST);
  assign w_sample    = (r_state == StSample) && w_phase_end;
  assign w_raw       = ACTIVE_LOW ? ~r_shift : r_shift;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div     <= '0;
      r_q7_meta <= 1'b0;
      r_q7_sync <= 1'b0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + 1'b1;
      r_q7_meta <= i_shifter_q7;
      r_q7_sync <= r_q7_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  // Ticks seen outside StIdle are simply ignored, which drops them.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_tick) w_state_next = StLoad;
      StLoad:   if (w_phase_end) w_state_next = StSample;
      StSample: if (w_phase_end) w_state_next = (r_bit_cnt == 3'd7) ? StDone : StShift;
      StShift:  if (w_phase_end) w_state_next = StSample;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    w_phase_next = (w_state_next != r_state) ? '0 : r_phase + 1'b1;
  end

  always_comb begin
    w_cnt_next = '0;
    if (w_raw == r_prev_raw) begin
      w_cnt_next = (r_stable_cnt >= CNT_THRESH) ? r_stable_cnt : r_stable_cnt + 1'b1;
    end
    w_accept = (w_cnt_next >= CNT_THRESH) && (w_raw != r_buttons);
  end

  // Pin drives are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pl_n        <= 1'b1;
      r_cp          <= 1'b0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_prev_raw    <= '0;
      r_buttons     <= '0;
      r_stable_cnt  <= '0;
      r_done_stb    <= 1'b0;
      r_changed_stb <= 1'b0;
    end else begin
      r_pl_n        <= (w_state_next != StLoad);
      r_cp          <= (w_state_next == StShift);
      r_done_stb    <= (r_state == StDone);
      r_changed_stb <= (r_state == StDone) && w_accept;
      if (w_sample) begin
        r_shift   <= {r_shift[6:0], r_q7_sync};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_state == StDone) begin
        r_stable_cnt <= w_cnt_next;
        r_prev_raw   <= w_raw;
        if (w_accept) r_buttons <= w_raw;
      end
    end
  end

  assign o_shifter_pl_n        = r_pl_n;
  assign o_shifter_cp          = r_cp;
  assign o_buttons             = r_buttons;
  assign o_buttons_changed_stb = r_changed_stb;
  assign o_scan_done_stb       = r_done_stb;

`ifdef HC165_READER_RAW_EN
  logic [7:0] r_raw;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_raw <= '0;
    end else if (r_state == StDone) begin
      r_raw <= w_raw;
    end
  end

  assign o_raw     = r_raw;
  assign o_raw_stb = r_done_stb;
`else
  // Raw observation ports are not built.
`endif

endmodule
